// File: rtl/regfile_write_demux.sv
// Register-file write side: valid/ready request intake, one-entry pending
// stage, registered 1-to-DEPTH one-hot demux and storage array.
// Ports:
//   CLK, RST_N (sync, active-low) : clock and reset
//   WR_VALID/WR_READY             : request handshake
//   WR_ADDR, WR_DATA              : destination register and data
//   HOLD                          : stalls commit of the pending entry
//   CLR                           : synchronous clear of storage and pending entry
//   WE_ONEHOT                     : registered one-hot enable of the pending write
//   PEND_VALID                    : pending entry occupied
//   REGS_FLAT                     : all words, word i at [i*WIDTH +: WIDTH]
// Optional macro REGFILE_WRITE_BYPASS_EN: forwards the pending data onto
// REGS_FLAT while the entry waits to commit.
module regfile_write_demux #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   WR_VALID,
  output logic                   WR_READY,
  input  logic [ADDR_W-1:0]      WR_ADDR,
  input  logic [WIDTH-1:0]       WR_DATA,
  input  logic                   HOLD,
  input  logic                   CLR,
  output logic [DEPTH-1:0]       WE_ONEHOT,
  output logic                   PEND_VALID,
  output logic [DEPTH*WIDTH-1:0] REGS_FLAT
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    data_q;
  logic [DEPTH-1:0]    we_q;
  logic [DEPTH-1:0]    we_d;
  logic [WIDTH-1:0]    regs_q [DEPTH];

  logic xfer;
  logic commit;
  logic wr_zero;

  assign WR_READY   = RST_N & ((state_q == EMPTY) | ~HOLD);
  assign xfer       = WR_VALID & WR_READY;
  assign commit     = (state_q == FULL) & ~HOLD;
  // Register 0 entries are consumed but never reach storage.
  assign wr_zero    = (ZERO_REG != 0) && (addr_q == '0);
  assign PEND_VALID = (state_q == FULL);
  assign WE_ONEHOT  = we_q;

  always_comb begin
    we_d = '0;
    we_d[WR_ADDR] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      // CLR wins over a simultaneous commit; the old write is dropped.
      if (CLR) begin
        for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (commit && !wr_zero) begin
        regs_q[addr_q] <= data_q;
      end

      if (xfer) begin
        state_q <= FULL;
        addr_q  <= WR_ADDR;
        data_q  <= WR_DATA;
        we_q    <= we_d;
      end else if (commit || CLR) begin
        state_q <= EMPTY;
        we_q    <= '0;
      end
    end
  end

  always_comb begin
    REGS_FLAT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      REGS_FLAT[i*WIDTH +: WIDTH] = regs_q[i];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if ((state_q == FULL) && !wr_zero) begin
      REGS_FLAT[int'(addr_q)*WIDTH +: WIDTH] = data_q;
    end
`else
`endif
  end

endmodule

// File: tb/tb_regfile_write_demux.sv
// Scoreboard bench for regfile_write_demux: directed stimulus pushes
// expectations, a negedge monitor pops and compares them.
module tb_regfile_write_demux;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic                   CLK = 1'b0;
  logic                   RST_N;
  logic                   WR_VALID;
  logic                   WR_READY;
  logic [ADDR_W-1:0]      WR_ADDR;
  logic [WIDTH-1:0]       WR_DATA;
  logic                   HOLD;
  logic                   CLR;
  logic [DEPTH-1:0]       WE_ONEHOT;
  logic                   PEND_VALID;
  logic [DEPTH*WIDTH-1:0] REGS_FLAT;

  regfile_write_demux #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ZERO_REG(1)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .WR_VALID(WR_VALID),
    .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .HOLD(HOLD),
    .CLR(CLR),
    .WE_ONEHOT(WE_ONEHOT),
    .PEND_VALID(PEND_VALID),
    .REGS_FLAT(REGS_FLAT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  localparam int S_WORD = 0;
  localparam int S_WE   = 1;
  localparam int S_PEND = 2;
  localparam int S_RDY  = 3;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always @(posedge CLK) cyc++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_v(string name, int sel, int idx, logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.sel  = sel;
    e.idx  = idx;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Monitor: compares everything queued for the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.sel)
          S_WORD:  act = REGS_FLAT[e.idx*WIDTH +: WIDTH];
          S_WE:    act = WE_ONEHOT;
          S_PEND:  act = {31'd0, PEND_VALID};
          default: act = {31'd0, WR_READY};
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)",
                   e.name, act, e.exp, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    RST_N    = 1'b0;
    WR_VALID = 1'b0;
    WR_ADDR  = '0;
    WR_DATA  = '0;
    HOLD     = 1'b0;
    CLR      = 1'b0;
    tick();
    tick();
    expect_v("rst_pend", S_PEND, 0, 0);
    expect_v("rst_we", S_WE, 0, 0);
    expect_v("rst_w5", S_WORD, 5, 0);
    expect_v("rst_rdy", S_RDY, 0, 0);
    tick();
    RST_N = 1'b1;
    expect_v("rdy_after_rst", S_RDY, 0, 1);

    // 1: single write to reg 5
    WR_VALID = 1'b1; WR_ADDR = 5; WR_DATA = 32'hDEADBEEF;
    tick();
    WR_VALID = 1'b0;
    expect_v("t1_we", S_WE, 0, 32'h20);
    expect_v("t1_pend", S_PEND, 0, 1);
    expect_v("t1_w5_early", S_WORD, 5, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    expect_v("t1_w5", S_WORD, 5, 32'hDEADBEEF);
    expect_v("t1_pend_clr", S_PEND, 0, 0);
    expect_v("t1_we_clr", S_WE, 0, 0);

    // 2: write to reg 0 is dropped
    WR_VALID = 1'b1; WR_ADDR = 0; WR_DATA = 32'h12345678;
    tick();
    WR_VALID = 1'b0;
    expect_v("t2_we", S_WE, 0, 32'h1);
    expect_v("t2_w0_pend", S_WORD, 0, 0);
    tick();
    expect_v("t2_w0", S_WORD, 0, 0);
    expect_v("t2_pend", S_PEND, 0, 0);

    // 3: back-to-back
    WR_VALID = 1'b1; WR_ADDR = 1; WR_DATA = 1;
    expect_v("t3_rdy0", S_RDY, 0, 1);
    tick();
    WR_ADDR = 2; WR_DATA = 2;
    expect_v("t3_rdy1", S_RDY, 0, 1);
    expect_v("t3_we1", S_WE, 0, 32'h2);
    tick();
    WR_ADDR = 3; WR_DATA = 3;
    expect_v("t3_rdy2", S_RDY, 0, 1);
    expect_v("t3_w1", S_WORD, 1, 1);
    expect_v("t3_we2", S_WE, 0, 32'h4);
    tick();
    WR_VALID = 1'b0;
    expect_v("t3_w2", S_WORD, 2, 2);
    expect_v("t3_we3", S_WE, 0, 32'h8);
    tick();
    expect_v("t3_w3", S_WORD, 3, 3);
    expect_v("t3_pend", S_PEND, 0, 0);

    // 4: hold with a waiting request
    WR_VALID = 1'b1; WR_ADDR = 7; WR_DATA = 32'hA5;
    tick();
    HOLD = 1'b1; WR_ADDR = 8; WR_DATA = 32'hB6;
    expect_v("t4_rdy_h0", S_RDY, 0, 0);
    expect_v("t4_we7", S_WE, 0, 32'h80);
    tick();
    expect_v("t4_rdy_h1", S_RDY, 0, 0);
    expect_v("t4_w7_h1", S_WORD, 7, BYP ? 32'hA5 : 32'h0);
    expect_v("t4_pend_h1", S_PEND, 0, 1);
    tick();
    expect_v("t4_rdy_h2", S_RDY, 0, 0);
    expect_v("t4_w8_h2", S_WORD, 8, 0);
    tick();
    HOLD = 1'b0;
    expect_v("t4_rdy_rel", S_RDY, 0, 1);
    tick();
    WR_VALID = 1'b0;
    expect_v("t4_w7", S_WORD, 7, 32'hA5);
    expect_v("t4_we8", S_WE, 0, 32'h100);
    tick();
    expect_v("t4_w8", S_WORD, 8, 32'hB6);
    expect_v("t4_pend", S_PEND, 0, 0);

    // 5: CLR at commit edge
    WR_VALID = 1'b1; WR_ADDR = 9; WR_DATA = 32'h55;
    tick();
    WR_VALID = 1'b0; CLR = 1'b1;
    expect_v("t5_we9", S_WE, 0, 32'h200);
    expect_v("t5_rdy_clr", S_RDY, 0, 1);
    tick();
    CLR = 1'b0;
    expect_v("t5_w9", S_WORD, 9, 0);
    expect_v("t5_w5", S_WORD, 5, 0);
    expect_v("t5_w7", S_WORD, 7, 0);
    expect_v("t5_w8", S_WORD, 8, 0);
    expect_v("t5_pend", S_PEND, 0, 0);

    // reset during a held entry
    WR_VALID = 1'b1; WR_ADDR = 10; WR_DATA = 32'h66;
    tick();
    WR_VALID = 1'b0; HOLD = 1'b1; RST_N = 1'b0;
    expect_v("t5_held_pend", S_PEND, 0, 1);
    expect_v("t5_rdy_inrst", S_RDY, 0, 0);
    tick();
    RST_N = 1'b1; HOLD = 1'b0;
    expect_v("t5_rst_pend", S_PEND, 0, 0);
    expect_v("t5_rst_we", S_WE, 0, 0);
    tick();
    expect_v("t5_w10", S_WORD, 10, 0);

    // CLR with a simultaneous transfer
    WR_VALID = 1'b1; WR_ADDR = 11; WR_DATA = 32'h11;
    tick();
    CLR = 1'b1; WR_ADDR = 12; WR_DATA = 32'h22;
    tick();
    CLR = 1'b0; WR_VALID = 1'b0;
    expect_v("t5_w11_lost", S_WORD, 11, 0);
    expect_v("t5_we12", S_WE, 0, 32'h1000);
    expect_v("t5_pend12", S_PEND, 0, 1);
    tick();
    expect_v("t5_w12", S_WORD, 12, 32'h22);

    // 6: bypass visibility
    WR_VALID = 1'b1; WR_ADDR = 4; WR_DATA = 32'h77;
    tick();
    WR_VALID = 1'b0;
    expect_v("t6_w4_early", S_WORD, 4, BYP ? 32'h77 : 32'h0);
    tick();
    expect_v("t6_w4", S_WORD, 4, 32'h77);
    expect_v("t6_w12", S_WORD, 12, 32'h22);

    tick();
    tick();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left expected 0", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
